// File: rtl/riscv_formal_monitor_pkg.sv
// Shared constants and decode helpers for the RV32IMC retirement monitor.
package riscv_formal_monitor_pkg;

    // Error codes reported on errcode; lower values take priority.
    typedef enum logic [15:0] {
        ERR_NONE     = 16'h0000,
        ERR_ORDER    = 16'h0001,
        ERR_PC       = 16'h0002,
        ERR_RS1      = 16'h0003,
        ERR_RS2      = 16'h0004,
        ERR_RD0      = 16'h0005,
        ERR_RS0      = 16'h0006,
        ERR_NEXTPC   = 16'h0007,
        ERR_MISALIGN = 16'h0008,
        ERR_MASK     = 16'h0009,
        ERR_MODE     = 16'h000B,
        ERR_PCODD    = 16'h000C
    } err_code_e;

    // 32-bit control-flow opcodes
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Compressed quadrants and control-flow funct3 values
    localparam logic [1:0] CQ1        = 2'b01;
    localparam logic [1:0] CQ2        = 2'b10;
    localparam logic [1:0] QUAD_32BIT = 2'b11;
    localparam logic [2:0] CF3_JAL    = 3'b001;
    localparam logic [2:0] CF3_J      = 3'b101;
    localparam logic [2:0] CF3_BEQZ   = 3'b110;
    localparam logic [2:0] CF3_BNEZ   = 3'b111;
    localparam logic [2:0] CF3_JR     = 3'b100;

    // True when a 32-bit opcode may redirect the PC
    function automatic logic is_cf_32(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

    // True for C.J, C.JAL, C.BEQZ, C.BNEZ, C.JR and C.JALR
    function automatic logic is_cf_c(input logic [1:0] quad, input logic [2:0] f3,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
        logic cf;
        cf = 1'b0;
        if (quad == CQ1) begin
            cf = (f3 == CF3_JAL) || (f3 == CF3_J) || (f3 == CF3_BEQZ) || (f3 == CF3_BNEZ);
        end else if (quad == CQ2) begin
            // C.JR/C.JALR need rs1!=0 and rs2==0; otherwise it is C.MV/C.ADD/C.EBREAK
            cf = (f3 == CF3_JR) && (rs1 != 5'd0) && (rs2 == 5'd0);
        end
        return cf;
    endfunction

    // Byte, aligned halfword or full word lane patterns only
    function automatic logic mask_legal(input logic [3:0] mask);
        return (mask == 4'b0001) || (mask == 4'b0010) || (mask == 4'b0100) ||
               (mask == 4'b1000) || (mask == 4'b0011) || (mask == 4'b1100) ||
               (mask == 4'b1111);
    endfunction

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow copy of x1..x31 with per-entry valid bits; x0 always reads as invalid zero.
module rvfi_shadow_regfile
    import riscv_formal_monitor_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ra1_i,
    output logic [31:0] rd1_o,
    output logic        rv1_o,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd2_o,
    output logic        rv2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] data_q [1:31];
    logic [31:1] valid_q;

    // Valid bits are cleared on reset and set by each write to a nonzero register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            valid_q[wa_i] <= 1'b1;
        end
    end

    // Data needs no reset because the valid bit gates every use of it
    always_ff @(posedge clk_i) begin
        if (we_i && (wa_i != 5'd0)) begin
            data_q[wa_i] <= wd_i;
        end
    end

    // Combinational reads see the state before this cycle's write
    always_comb begin
        rd1_o = '0;
        rv1_o = 1'b0;
        rd2_o = '0;
        rv2_o = 1'b0;
        if (ra1_i != 5'd0) begin
            rd1_o = data_q[ra1_i];
            rv1_o = valid_q[ra1_i];
        end
        if (ra2_i != 5'd0) begin
            rd2_o = data_q[ra2_i];
            rv2_o = valid_q[ra2_i];
        end
    end

endmodule

// File: rtl/riscv_formal_monitor_rv32imc.sv
// RVFI retirement monitor for RV32IMC: checks ordering, PC flow, register
// consistency and memory masks, reporting the first error as a sticky code.
module riscv_formal_monitor_rv32imc
    import riscv_formal_monitor_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_halt,
    input  logic        rvfi_intr,
    input  logic [1:0]  rvfi_mode,
    input  logic [4:0]  rvfi_rs1_addr,
    input  logic [4:0]  rvfi_rs2_addr,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rs1_rdata,
    input  logic [31:0] rvfi_rs2_rdata,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_pc_wdata,
    input  logic [31:0] rvfi_mem_addr,
    input  logic [3:0]  rvfi_mem_rmask,
    input  logic [3:0]  rvfi_mem_wmask,
    input  logic [31:0] rvfi_mem_rdata,
    input  logic [31:0] rvfi_mem_wdata,
    input  logic        rvfi_mem_extamo,
    output logic [15:0] errcode
);

    logic [63:0] order_q, order_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic [15:0] errcode_q, errcode_d;

    logic        check_active;
    logic        is_compressed;
    logic        is_cf;
    logic [31:0] pc_step;
    logic        mask_bad;
    logic [15:0] err_now;

    logic [31:0] shadow_rs1, shadow_rs2;
    logic        shadow_rs1_valid, shadow_rs2_valid;

    // Data lanes and bits the decoder never looks at are deliberately ignored
    logic unused_ok;
    assign unused_ok = ^{rvfi_mem_rdata, rvfi_mem_wdata, rvfi_insn[31:16],
                         rvfi_insn[12], rvfi_mem_addr[31:2]};

    assign check_active  = !reset && rvfi_valid && !rvfi_halt;
    assign is_compressed = (rvfi_insn[1:0] != QUAD_32BIT);
    assign is_cf         = is_compressed
                         ? is_cf_c(rvfi_insn[1:0], rvfi_insn[15:13], rvfi_insn[11:7], rvfi_insn[6:2])
                         : is_cf_32(rvfi_insn[6:0]);
    assign pc_step       = is_compressed ? 32'd2 : 32'd4;
    assign mask_bad      = ((rvfi_mem_rmask != 4'd0) && !mask_legal(rvfi_mem_rmask)) ||
                           ((rvfi_mem_wmask != 4'd0) && !mask_legal(rvfi_mem_wmask)) ||
                           ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0) && !rvfi_mem_extamo);

    rvfi_shadow_regfile u_shadow (
        .clk_i (clock),
        .rst_i (reset),
        .ra1_i (rvfi_rs1_addr),
        .rd1_o (shadow_rs1),
        .rv1_o (shadow_rs1_valid),
        .ra2_i (rvfi_rs2_addr),
        .rd2_o (shadow_rs2),
        .rv2_o (shadow_rs2_valid),
        .we_i  (check_active && (rvfi_rd_addr != 5'd0)),
        .wa_i  (rvfi_rd_addr),
        .wd_i  (rvfi_rd_wdata)
    );

    // Evaluate all checks, lowest-numbered failing check wins
    always_comb begin
        err_now = ERR_NONE;
        if (rvfi_order != order_q) begin
            err_now = ERR_ORDER;
        end else if (pc_valid_q && (rvfi_pc_rdata != last_pc_q)) begin
            err_now = ERR_PC;
        end else if ((rvfi_rs1_addr != 5'd0) && shadow_rs1_valid && (rvfi_rs1_rdata != shadow_rs1)) begin
            err_now = ERR_RS1;
        end else if ((rvfi_rs2_addr != 5'd0) && shadow_rs2_valid && (rvfi_rs2_rdata != shadow_rs2)) begin
            err_now = ERR_RS2;
        end else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0)) begin
            err_now = ERR_RD0;
        end else if (((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != 32'd0)) ||
                     ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != 32'd0))) begin
            err_now = ERR_RS0;
        end else if (!is_cf && (rvfi_pc_wdata != rvfi_pc_rdata + pc_step)) begin
            err_now = ERR_NEXTPC;
        end else if (((rvfi_mem_rmask | rvfi_mem_wmask) != 4'd0) && (rvfi_mem_addr[1:0] != 2'b00)) begin
            err_now = ERR_MISALIGN;
        end else if (mask_bad) begin
            err_now = ERR_MASK;
        end else if (rvfi_trap || rvfi_intr || (rvfi_mode != 2'd0)) begin
            err_now = ERR_MODE;
        end else if (rvfi_pc_wdata[0]) begin
            err_now = ERR_PCODD;
        end
    end

    // Advance history on every checked retirement and latch the first error
    always_comb begin
        order_d    = order_q;
        last_pc_d  = last_pc_q;
        pc_valid_d = pc_valid_q;
        errcode_d  = errcode_q;
        if (check_active) begin
            order_d    = order_q + 64'd1;
            last_pc_d  = rvfi_pc_wdata;
            pc_valid_d = 1'b1;
            if ((errcode_q == 16'd0) && (err_now != 16'd0)) begin
                errcode_d = err_now;
            end
        end
    end

    // Monitor state register; reset discards all history
    always_ff @(posedge clock) begin
        if (reset) begin
            order_q    <= '0;
            last_pc_q  <= '0;
            pc_valid_q <= 1'b0;
            errcode_q  <= '0;
        end else begin
            order_q    <= order_d;
            last_pc_q  <= last_pc_d;
            pc_valid_q <= pc_valid_d;
            errcode_q  <= errcode_d;
        end
    end

    assign errcode = errcode_q;

endmodule

// File: tb/tb_riscv_formal_monitor_rv32imc.sv
// Directed bench for the RVFI monitor: stimulus pushes the expected errcode
// for each cycle into a queue and a monitor process compares after the edge.
module tb_riscv_formal_monitor_rv32imc;

    logic        clock;
    logic        reset;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap, rvfi_halt, rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
    logic        rvfi_mem_extamo;
    logic [15:0] errcode;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   stimDone = 0;

    riscv_formal_monitor_rv32imc dut (
        .clock           (clock),
        .reset           (reset),
        .rvfi_valid      (rvfi_valid),
        .rvfi_order      (rvfi_order),
        .rvfi_insn       (rvfi_insn),
        .rvfi_trap       (rvfi_trap),
        .rvfi_halt       (rvfi_halt),
        .rvfi_intr       (rvfi_intr),
        .rvfi_mode       (rvfi_mode),
        .rvfi_rs1_addr   (rvfi_rs1_addr),
        .rvfi_rs2_addr   (rvfi_rs2_addr),
        .rvfi_rd_addr    (rvfi_rd_addr),
        .rvfi_rs1_rdata  (rvfi_rs1_rdata),
        .rvfi_rs2_rdata  (rvfi_rs2_rdata),
        .rvfi_rd_wdata   (rvfi_rd_wdata),
        .rvfi_pc_rdata   (rvfi_pc_rdata),
        .rvfi_pc_wdata   (rvfi_pc_wdata),
        .rvfi_mem_addr   (rvfi_mem_addr),
        .rvfi_mem_rmask  (rvfi_mem_rmask),
        .rvfi_mem_wmask  (rvfi_mem_wmask),
        .rvfi_mem_rdata  (rvfi_mem_rdata),
        .rvfi_mem_wdata  (rvfi_mem_wdata),
        .rvfi_mem_extamo (rvfi_mem_extamo),
        .errcode         (errcode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Return every RVFI field to an idle, zero value
    task automatic clearBus();
        rvfi_valid      = 1'b0;
        rvfi_order      = '0;
        rvfi_insn       = '0;
        rvfi_trap       = 1'b0;
        rvfi_halt       = 1'b0;
        rvfi_intr       = 1'b0;
        rvfi_mode       = '0;
        rvfi_rs1_addr   = '0;
        rvfi_rs2_addr   = '0;
        rvfi_rd_addr    = '0;
        rvfi_rs1_rdata  = '0;
        rvfi_rs2_rdata  = '0;
        rvfi_rd_wdata   = '0;
        rvfi_pc_rdata   = '0;
        rvfi_pc_wdata   = '0;
        rvfi_mem_addr   = '0;
        rvfi_mem_rmask  = '0;
        rvfi_mem_wmask  = '0;
        rvfi_mem_rdata  = 32'hDEAD_BEEF;
        rvfi_mem_wdata  = 32'hCAFE_F00D;
        rvfi_mem_extamo = 1'b0;
    endtask

    // Record what errcode must be after the coming edge, then hold for one cycle
    task automatic applyStimulus(input logic [15:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        expQ.push_back(e);
        @(negedge clock);
    endtask

    // One retirement; memory and flag fields keep whatever the caller set
    task automatic retire(input logic [63:0] ord, input logic [31:0] insn,
                          input logic [31:0] pcR, input logic [31:0] pcW,
                          input logic [4:0] rdA, input logic [31:0] rdW,
                          input logic [4:0] r1A, input logic [31:0] r1D,
                          input logic [4:0] r2A, input logic [31:0] r2D,
                          input logic [15:0] exp, input string name);
        rvfi_valid     = 1'b1;
        rvfi_order     = ord;
        rvfi_insn      = insn;
        rvfi_pc_rdata  = pcR;
        rvfi_pc_wdata  = pcW;
        rvfi_rd_addr   = rdA;
        rvfi_rd_wdata  = rdW;
        rvfi_rs1_addr  = r1A;
        rvfi_rs1_rdata = r1D;
        rvfi_rs2_addr  = r2A;
        rvfi_rs2_rdata = r2D;
        applyStimulus(exp, name);
        clearBus();
    endtask

    // Two reset cycles, the first carrying a bogus retirement that must be ignored
    task automatic doReset();
        clearBus();
        reset      = 1'b1;
        rvfi_valid = 1'b1;
        rvfi_order = 64'd77;
        rvfi_pc_wdata = 32'h1;
        applyStimulus(16'h0000, "reset_with_retire");
        clearBus();
        applyStimulus(16'h0000, "reset_hold");
        reset = 1'b0;
    endtask

    // Compare one scoreboard entry against the DUT output
    task automatic checkOutput(input exp_t e);
        checks++;
        if (errcode !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s: errcode=0x%04h expected 0x%04h", e.name, errcode, e.exp);
        end
    endtask

    // Monitor: one entry pending at an edge means errcode is due just after it
    initial begin
        forever begin
            @(posedge clock);
            if (expQ.size() > 0) begin
                #1;
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Directed scenarios with hand-computed codes
    initial begin
        clearBus();
        reset = 1'b1;
        @(negedge clock);
        doReset();

        // addi x1,x0,5 then a halted retirement, an idle cycle and dependent ops
        retire(0, 32'h0050_0093, 32'h0, 32'h4, 5'd1, 32'd5, 5'd0, 0, 5'd0, 0, 16'h0000, "addi_x1");
        rvfi_halt = 1'b1;
        retire(99, 32'h0000_0013, 32'h50, 32'h51, 5'd0, 32'd9, 5'd0, 7, 5'd0, 0, 16'h0000, "halt_ignored");
        applyStimulus(16'h0000, "idle");
        retire(1, 32'h0010_8113, 32'h4, 32'h8, 5'd2, 32'd6, 5'd1, 32'd5, 5'd0, 0, 16'h0000, "addi_x2_x1");
        retire(2, 32'h1F80_006F, 32'h8, 32'h200, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h0000, "jal_0x200");
        retire(3, 32'h0000_0085, 32'h200, 32'h202, 5'd1, 32'd6, 5'd1, 32'd5, 5'd0, 0, 16'h0000, "c_addi_ok");
        retire(5, 32'h0000_0013, 32'h202, 32'h206, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h0001, "order_skip");
        retire(5, 32'h0000_0013, 32'h206, 32'h20A, 5'd0, 32'd1, 5'd0, 0, 5'd0, 0, 16'h0001, "order_sticky");
        applyStimulus(16'h0001, "sticky_idle");

        // Reset clears the sticky code; stale rs1 read after x1=5
        doReset();
        retire(0, 32'h0050_0093, 32'h0, 32'h4, 5'd1, 32'd5, 5'd0, 0, 5'd0, 0, 16'h0000, "addi_x1_b");
        retire(1, 32'h0000_81B3, 32'h4, 32'h8, 5'd3, 32'd6, 5'd1, 32'd6, 5'd0, 0, 16'h0003, "rs1_mismatch");

        // Compressed non-control-flow must step by 2
        doReset();
        retire(0, 32'h0000_0085, 32'h100, 32'h104, 5'd1, 32'd1, 5'd1, 0, 5'd0, 0, 16'h0007, "c_addi_bad_next");

        // Jumps may go anywhere; a later PC discontinuity is caught
        doReset();
        retire(0, 32'h1000_006F, 32'h100, 32'h200, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h0000, "jal_ok");
        retire(1, 32'h0000_A001, 32'h200, 32'h300, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h0000, "c_j_ok");
        retire(2, 32'h0000_0013, 32'h304, 32'h308, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h0002, "pc_discontinuity");

        // Misaligned load with an illegal mask reports the lower code
        doReset();
        rvfi_mem_rmask = 4'b0101;
        rvfi_mem_addr  = 32'h1002;
        retire(0, 32'h0000_2283, 32'h0, 32'h4, 5'd5, 0, 5'd0, 0, 5'd0, 0, 16'h0008, "misaligned_load");

        // Illegal mask alone
        doReset();
        rvfi_mem_rmask = 4'b0101;
        rvfi_mem_addr  = 32'h1000;
        retire(0, 32'h0000_2283, 32'h0, 32'h4, 5'd5, 0, 5'd0, 0, 5'd0, 0, 16'h0009, "illegal_rmask");

        // Read plus write is legal only for an AMO
        doReset();
        rvfi_mem_rmask  = 4'b1111;
        rvfi_mem_wmask  = 4'b1111;
        rvfi_mem_addr   = 32'h2000;
        rvfi_mem_extamo = 1'b1;
        retire(0, 32'h0000_202F, 32'h0, 32'h4, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h0000, "amo_rw_ok");
        rvfi_mem_rmask  = 4'b1111;
        rvfi_mem_wmask  = 4'b1111;
        rvfi_mem_addr   = 32'h2000;
        retire(1, 32'h0000_2023, 32'h4, 32'h8, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h0009, "rw_without_amo");

        // Trap flag and odd next PC
        doReset();
        rvfi_trap = 1'b1;
        retire(0, 32'h0000_0013, 32'h0, 32'h4, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h000B, "trap");
        doReset();
        retire(0, 32'h1000_006F, 32'h100, 32'h201, 5'd0, 0, 5'd0, 0, 5'd0, 0, 16'h000C, "odd_next_pc");

        // x0 read returning nonzero
        doReset();
        retire(0, 32'h0000_0013, 32'h0, 32'h4, 5'd0, 0, 5'd0, 32'd3, 5'd0, 0, 16'h0006, "x0_read_nonzero");

        // rs2 mismatch together with an x0 write: lower code wins
        doReset();
        retire(0, 32'h0050_0093, 32'h0, 32'h4, 5'd1, 32'd5, 5'd0, 0, 5'd0, 0, 16'h0000, "addi_x1_c");
        retire(1, 32'h0010_0033, 32'h4, 32'h8, 5'd0, 32'd1, 5'd0, 0, 5'd1, 32'd7, 16'h0004, "rs2_and_rd0");

        // c.jr is control flow; then x0 write, reset pulse and clean restart
        doReset();
        retire(0, 32'h0000_8082, 32'h10, 32'h40, 5'd0, 0, 5'd1, 0, 5'd0, 0, 16'h0000, "c_jr_ok");
        retire(1, 32'h0000_0013, 32'h40, 32'h44, 5'd0, 32'd1, 5'd0, 0, 5'd0, 0, 16'h0005, "rd0_write");
        doReset();
        retire(0, 32'h0050_0093, 32'h0, 32'h4, 5'd1, 32'd5, 5'd0, 0, 5'd0, 0, 16'h0000, "restart_order0");
        retire(1, 32'h0000_81B3, 32'h4, 32'h8, 5'd3, 32'd5, 5'd1, 32'd5, 5'd0, 0, 16'h0000, "restart_rs1_ok");
        applyStimulus(16'h0000, "final_idle");

        stimDone = 1'b1;
    end

    // Wait for stimulus and scoreboard drain within a fixed cycle budget
    initial begin
        int cycles;
        cycles = 0;
        while (!(stimDone && expQ.size() == 0) && cycles < 2000) begin
            @(negedge clock);
            cycles++;
        end
        if (!(stimDone && expQ.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: pending=%0d expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_formal_monitor_rv32imc.md
RISCV_FORMAL_MONITOR_RV32IMC -- requirements
Module: riscv_formal_monitor_rv32imc

Interface
REQ-001 SHALL have parameters: none; all widths fixed for RV32 with one retirement per cycle.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- rvfi_valid  in  1  one instruction retires this cycle
- rvfi_order  in  64  retirement index
- rvfi_insn  in  32  instruction word; 16-bit compressed in [15:0] when [1:0]!=2'b11
- rvfi_trap, rvfi_halt, rvfi_intr  in  1 each  trap, halt and interrupt flags
- rvfi_mode  in  2  privilege mode
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  in  5 each  register indices
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  in  32 each  register data
- rvfi_pc_rdata, rvfi_pc_wdata  in  32 each  PC of this instruction and of the next instruction
- rvfi_mem_addr  in  32  word-aligned memory address
- rvfi_mem_rmask, rvfi_mem_wmask  in  4 each  byte-lane masks
- rvfi_mem_rdata, rvfi_mem_wdata  in  32 each  memory data
- rvfi_mem_extamo  in  1  AMO flag
- errcode  out  16  0 means no error, otherwise the first detected error code

Function
REQ-003 SHALL evaluate checks only in cycles where reset=0, rvfi_valid=1 and rvfi_halt=0; a retirement with rvfi_halt=1 is ignored entirely (no checks, no state update).
REQ-004 SHALL keep an expected order counter, 0 after reset, incremented by 1 per checked retirement; rvfi_order != expected -> code 0x0001.
REQ-005 SHALL keep the last pc_wdata plus a pc-valid flag; with the flag set, pc_rdata != last pc_wdata -> code 0x0002.
REQ-006 SHALL keep a shadow register file x1..x31, each entry with a valid bit; rsN_addr!=0, entry valid and rsN_rdata != shadow -> code 0x0003 (rs1) or 0x0004 (rs2).
REQ-007 SHALL flag rd_addr==0 with rd_wdata!=0 -> 0x0005; rsN_addr==0 with rsN_rdata!=0 -> 0x0006.
REQ-008 SHALL decode non-control-flow instructions and require pc_wdata == pc_rdata+4 (32-bit) or +2 (compressed), else 0x0007.
- Control-flow exclusions, 32-bit: opcode[6:0] 1100011, 1101111, 1100111.
- Control-flow exclusions, compressed: C.J, C.JAL, C.JR, C.JALR, C.BEQZ, C.BNEZ.
REQ-009 SHALL flag rmask|wmask nonzero with mem_addr[1:0]!=0 -> 0x0008.
REQ-010 SHALL flag an illegal mask -> 0x0009.
- Legal nonzero masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Both rmask and wmask nonzero is also illegal unless rvfi_mem_extamo=1.
REQ-011 SHALL flag rvfi_trap=1, rvfi_intr=1 or rvfi_mode!=0 -> 0x000B; pc_wdata[0]=1 -> 0x000C.
REQ-012 SHALL, when several checks fail together, select the numerically lowest code.
REQ-013 SHALL register errcode at the next clock edge after a failing retirement (latency 1); errcode is sticky, keeping the first nonzero code until reset.
REQ-014 SHALL, on each checked retirement, update state at the same edge:
- order counter increments
- last PC <- pc_wdata and the pc-valid flag is set
- if rd_addr!=0, shadow[rd] <- rd_wdata and its valid bit is set
REQ-015 SHALL compare rs reads of a retirement against shadow state from before that retirement's own rd write.
REQ-016 SHALL treat mem_rdata and mem_wdata lanes as don't-care; they are not checked.

Reset
REQ-017 SHALL, while reset=1, set errcode=0, clear the order counter, pc-valid flag and all shadow valid bits, and perform no checks.
REQ-018 SHALL resume checking on the first cycle after reset deasserts; a reset mid-run discards all history.

Structure
REQ-019 SHALL place the error-code constants (0x0001..0x000C) and the opcode/compressed-funct constants in a shared package, riscv_formal_monitor_pkg.
REQ-020 SHALL implement the shadow register file as the sub-module rvfi_shadow_regfile:
- 31x32 data plus valid bits
- 2 read ports, 1 write port, synchronous write, synchronous clear on reset

Verification
REQ-021 Reset, then retire addi x1,x0,5: order 0, pc 0x0->0x4, rd_wdata 5 -> errcode stays 0.
REQ-022 Next retirement with order 2 instead of 1 -> errcode=0x0001 one cycle later and held through later retirements.
REQ-023 Retire with rs1_addr=1, rs1_rdata=6 after x1 was written 5 -> errcode=0x0003.
REQ-024 Compressed c.addi at pc 0x100 with pc_wdata 0x104 -> 0x0007; the same case with a jal to 0x200 -> no error.
REQ-025 Load with rmask=0101 and mem_addr 0x1002 -> 0x0008 (lowest code wins over 0x0009).
REQ-026 rd_addr=0 with rd_wdata=1, then reset pulse -> 0x0005, then errcode=0 after reset and clean checking resumes from order 0.
